// File: rtl/sram_rw0_ctrl_if.sv
// Request/response bus between a client and the single-port SRAM controller.
//   rreq_valid/rreq_ready/rreq_addr            : read-request channel
//   wreq_valid/wreq_ready/wreq_addr/wreq_data  : write-request channel
//   resp_valid/resp_ready/resp_data            : read-response channel (read-issue order)
// master = client side, slave = controller side.
interface sram_rw0_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              rreq_valid;
    logic              rreq_ready;
    logic [ADDR_W-1:0] rreq_addr;
    logic              wreq_valid;
    logic              wreq_ready;
    logic [ADDR_W-1:0] wreq_addr;
    logic [DATA_W-1:0] wreq_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output rreq_valid, rreq_addr, wreq_valid, wreq_addr, wreq_data, resp_ready,
        input  rreq_ready, wreq_ready, resp_valid, resp_data
    );

    modport slave (
        input  rreq_valid, rreq_addr, wreq_valid, wreq_addr, wreq_data, resp_ready,
        output rreq_ready, wreq_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/sram_rw0_ctrl.sv
// Controller for a single-port (RW0) SRAM macro: arbitrates read and write
// requests onto the one port (one access per cycle, round-robin when both
// compete) and returns read data through a 3-entry response FIFO.
// Ports:
//   RW0_clk    : clock shared with the SRAM macro
//   reset      : synchronous, active-high
//   bus        : request/response bus (slave modport)
//   RW0_en     : SRAM port enable
//   RW0_wmode  : 1 = write access, 0 = read access
//   RW0_addr   : SRAM word address
//   RW0_wdata  : SRAM write data (0 when not writing)
//   RW0_rdata  : SRAM read data, valid the cycle after a read access
module sram_rw0_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              RW0_clk,
    input  logic              reset,
    sram_rw0_ctrl_if.slave    bus,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam int FIFO_DEPTH = 3;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [1:0]        wr_ptr_reg, wr_ptr_next;
    logic [1:0]        rd_ptr_reg, rd_ptr_next;
    logic [1:0]        count_reg, count_next;
    logic              inflight_reg;
    logic              last_write_reg;   // 1: write won the last grant

    logic [2:0] occupancy;
    logic       read_elig;
    logic       read_fire;
    logic       write_fire;
    logic       push;
    logic       pop;

    // A read needs a FIFO slot reserved for its data, counting the read whose
    // data is still coming back from the SRAM.
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg};
    assign read_elig = (occupancy < 3'(FIFO_DEPTH));

    // Exactly one of the two readies is high whenever both requests are valid
    // and a read is possible, so a read and a write can never fire together.
    assign bus.rreq_ready = !reset && read_elig && (!bus.wreq_valid || last_write_reg);
    assign bus.wreq_ready = !reset && (!bus.rreq_valid || !read_elig || !last_write_reg);

    assign read_fire  = bus.rreq_valid && bus.rreq_ready;
    assign write_fire = bus.wreq_valid && bus.wreq_ready;

    assign RW0_en    = read_fire || write_fire;
    assign RW0_wmode = write_fire;
    assign RW0_addr  = write_fire ? bus.wreq_addr : bus.rreq_addr;
    assign RW0_wdata = write_fire ? bus.wreq_data : '0;

    // Response FIFO
    assign push           = inflight_reg;
    assign bus.resp_valid = !reset && (count_reg != 2'd0);
    assign bus.resp_data  = fifo_mem[rd_ptr_reg];
    assign pop            = bus.resp_valid && bus.resp_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == 2'(FIFO_DEPTH - 1)) ? 2'd0 : wr_ptr_reg + 2'd1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == 2'(FIFO_DEPTH - 1)) ? 2'd0 : rd_ptr_reg + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Data entries carry no reset: occupancy is governed by the pointers.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge RW0_clk) begin
                if (push && (wr_ptr_reg == 2'(gi))) begin
                    fifo_mem[gi] <= RW0_rdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge RW0_clk) begin
        if (reset) begin
            wr_ptr_reg     <= 2'd0;
            rd_ptr_reg     <= 2'd0;
            count_reg      <= 2'd0;
            inflight_reg   <= 1'b0;
            last_write_reg <= 1'b0;   // next contested grant goes to the write
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            inflight_reg <= read_fire;
            if (read_fire || write_fire) begin
                last_write_reg <= write_fire;
            end
        end
    end

endmodule

// File: tb/tb_sram_rw0_ctrl.sv
// Directed bench for sram_rw0_ctrl with a behavioural SRAM macro, a reference
// memory and a queue of expected read responses.
module tb_sram_rw0_ctrl;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    logic              RW0_clk = 1'b0;
    logic              reset;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [ADDR_W-1:0] RW0_addr;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;

    sram_rw0_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_rw0_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .RW0_clk   (RW0_clk),
        .reset     (reset),
        .bus       (bus.slave),
        .RW0_en    (RW0_en),
        .RW0_wmode (RW0_wmode),
        .RW0_addr  (RW0_addr),
        .RW0_wdata (RW0_wdata),
        .RW0_rdata (RW0_rdata)
    );

    always #5 RW0_clk = ~RW0_clk;

    function automatic logic [DATA_W-1:0] pattern(input int a);
        return DATA_W'(a * 97 + 16'h03C1);
    endfunction

    // SRAM macro: unwritten words read back as pattern(addr).
    logic [DATA_W-1:0] sram_mem [1 << ADDR_W];
    bit                sram_wr  [1 << ADDR_W];
    always @(posedge RW0_clk) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                sram_mem[RW0_addr] <= RW0_wdata;
                sram_wr[RW0_addr]  <= 1'b1;
            end else begin
                RW0_rdata <= sram_wr[RW0_addr] ? sram_mem[RW0_addr] : pattern(int'(RW0_addr));
            end
        end
    end

    // Reference memory and expected-response queue
    logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
    bit                ref_wr  [1 << ADDR_W];
    logic [DATA_W-1:0] exp_q [$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock cycle: at the falling edge score handshakes, then step to
    // just after the next rising edge where new inputs are driven.
    task automatic cyc();
        logic [DATA_W-1:0] e;
        @(negedge RW0_clk);
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.resp_valid && bus.resp_ready) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected_resp: observed %0h expected none", bus.resp_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_resp_data", 32'(bus.resp_data), 32'(e));
                end
            end
            if (bus.rreq_valid && bus.rreq_ready) begin
                exp_q.push_back(ref_wr[bus.rreq_addr] ? ref_mem[bus.rreq_addr]
                                                      : pattern(int'(bus.rreq_addr)));
            end
            if (bus.wreq_valid && bus.wreq_ready) begin
                ref_mem[bus.wreq_addr] = bus.wreq_data;
                ref_wr[bus.wreq_addr]  = 1'b1;
            end
        end
        @(posedge RW0_clk);
        #1;
    endtask

    task automatic idle();
        bus.rreq_valid = 1'b0;
        bus.wreq_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        idle();
        bus.resp_ready = 1'b1;
        while (exp_q.size() != 0 && k < 20) begin
            cyc();
            k++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    int n_acc;

    initial begin
        reset          = 1'b1;
        bus.rreq_valid = 1'b1;
        bus.rreq_addr  = 9'h020;
        bus.wreq_valid = 1'b1;
        bus.wreq_addr  = 9'h010;
        bus.wreq_data  = 16'hA0A0;
        bus.resp_ready = 1'b1;

        // Reset holds everything idle even with requests pending
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("rst_RW0_en", 32'(RW0_en), 32'd0);
            chk("rst_rreq_ready", 32'(bus.rreq_ready), 32'd0);
            chk("rst_wreq_ready", 32'(bus.wreq_ready), 32'd0);
            chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            cyc();
        end

        // Both requesters contend: W,R,W,R
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rr_RW0_en", 32'(RW0_en), 32'd1);
            chk("rr_wmode", 32'(RW0_wmode), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_wdata", 32'(RW0_wdata), (i % 2 == 0) ? 32'hA0A0 : 32'd0);
            cyc();
        end
        drain("rr_drained");

        // Write 0x1234 @0x005 then read it back at 2-cycle latency
        bus.wreq_valid = 1'b1;
        bus.wreq_addr  = 9'h005;
        bus.wreq_data  = 16'h1234;
        #2;
        chk("wr5_RW0_en", 32'(RW0_en), 32'd1);
        chk("wr5_wmode", 32'(RW0_wmode), 32'd1);
        chk("wr5_addr", 32'(RW0_addr), 32'h005);
        chk("wr5_wdata", 32'(RW0_wdata), 32'h1234);
        cyc();
        bus.wreq_valid = 1'b0;
        bus.rreq_valid = 1'b1;
        bus.rreq_addr  = 9'h005;
        #2;
        chk("rd5_ready", 32'(bus.rreq_ready), 32'd1);
        chk("rd5_wmode", 32'(RW0_wmode), 32'd0);
        cyc();
        bus.rreq_valid = 1'b0;
        #2;
        chk("rd5_lat1_valid", 32'(bus.resp_valid), 32'd0);
        cyc();
        #2;
        chk("rd5_lat2_valid", 32'(bus.resp_valid), 32'd1);
        chk("rd5_lat2_data", 32'(bus.resp_data), 32'h1234);
        drain("rd5_drained");

        // Back-to-back reads of 0..7
        for (int i = 0; i < 8; i++) begin
            bus.rreq_valid = 1'b1;
            bus.rreq_addr  = 9'(i);
            #2;
            chk("bb_rreq_ready", 32'(bus.rreq_ready), 32'd1);
            if (i >= 2) chk("bb_resp_valid", 32'(bus.resp_valid), 32'd1);
            cyc();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("bb_tail_valid", 32'(bus.resp_valid), 32'd1);
            cyc();
        end
        drain("bb_drained");

        // Back-pressure: 3 reads accepted, then stall; writes still granted
        bus.resp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.rreq_valid = 1'b1;
            bus.rreq_addr  = 9'(9'h050 + 9'(n_acc));
            bus.wreq_valid = (i == 5);
            bus.wreq_addr  = 9'h060;
            bus.wreq_data  = 16'h6060;
            #2;
            if (bus.rreq_ready) n_acc++;
            if (i == 5) chk("stall_wreq_ready", 32'(bus.wreq_ready), 32'd1);
            cyc();
        end
        bus.wreq_valid = 1'b0;
        #2;
        chk("stall_accepted", 32'(n_acc), 32'd3);
        chk("stall_rreq_ready", 32'(bus.rreq_ready), 32'd0);
        chk("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
        bus.rreq_valid = 1'b0;
        drain("stall_drained");
        bus.rreq_valid = 1'b1;
        bus.rreq_addr  = 9'h060;
        #2;
        chk("stall_resume", 32'(bus.rreq_ready), 32'd1);
        cyc();
        drain("resume_drained");

        // Top address write-then-read hazard
        bus.wreq_valid = 1'b1;
        bus.wreq_addr  = 9'h1FF;
        bus.wreq_data  = 16'hBEEF;
        cyc();
        bus.wreq_valid = 1'b0;
        bus.rreq_valid = 1'b1;
        bus.rreq_addr  = 9'h1FF;
        #2;
        chk("top_rreq_ready", 32'(bus.rreq_ready), 32'd1);
        cyc();
        idle();
        cyc();
        #2;
        chk("top_resp_data", 32'(bus.resp_data), 32'hBEEF);
        drain("top_drained");

        // Reset mid-operation discards in-flight read
        bus.wreq_valid = 1'b1;
        bus.wreq_addr  = 9'h033;
        bus.wreq_data  = 16'hCAFE;
        cyc();
        bus.wreq_valid = 1'b0;
        bus.rreq_valid = 1'b1;
        bus.rreq_addr  = 9'h040;
        cyc();
        bus.rreq_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            cyc();
        end
        bus.rreq_valid = 1'b1;
        bus.rreq_addr  = 9'h033;
        cyc();
        idle();
        cyc();
        #2;
        chk("post_rst_valid", 32'(bus.resp_valid), 32'd1);
        chk("post_rst_data", 32'(bus.resp_data), 32'hCAFE);
        drain("final_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_rw0_ctrl.md
SRAM_RW0_CTRL -- requirements
Module: sram_rw0_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9: SRAM word-address width.
REQ-002 Parameter DATA_W, default 16: SRAM data width, no write mask.
REQ-003 clock  in  1  single clock for all state; the SRAM macro runs on the same clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rreq_valid/rreq_ready  in/out  1/1  read-request handshake.
REQ-006 rreq_addr  in  ADDR_W  read address.
REQ-007 wreq_valid/wreq_ready  in/out  1/1  write-request handshake.
REQ-008 wreq_addr/wreq_data  in  ADDR_W/DATA_W  write address and data.
REQ-009 resp_valid/resp_ready  out/in  1/1  read-response handshake.
REQ-010 resp_data  out  DATA_W  read data, in read-issue order.
REQ-011 RW0_en/RW0_wmode  out  1/1  SRAM port enable and write select (1 = write).
REQ-012 RW0_addr/RW0_wdata  out  ADDR_W/DATA_W  SRAM address and write data.
REQ-013 RW0_rdata  in  DATA_W  SRAM read data, valid the cycle after a read-enable cycle.

Function
REQ-014 A channel fires when valid && ready; at most one SRAM access per cycle, either a read or a write.
REQ-015 Read eligible only when credit = 3 - fifo_count - inflight > 0; write always eligible.
REQ-016 One eligible requester: it is granted. Both eligible and valid: round-robin, the one not granted last wins; a lone grant also updates the last-granted flag.
REQ-017 rreq_ready = read eligible && (!wreq_valid || rr favours read); wreq_ready = !rreq_valid || !read eligible || rr favours write.
REQ-018 RW0_en = read fire || write fire; RW0_wmode = write fire; RW0_addr/RW0_wdata combinationally from the granted request; RW0_wdata = 0 when not writing.
REQ-019 A read fire in cycle N sets inflight for cycle N+1; in N+1, RW0_rdata is pushed into the 3-entry response FIFO.
REQ-020 resp_valid = FIFO non-empty; resp_data = FIFO head; pop on resp_valid && resp_ready.
REQ-021 Read-handshake-to-resp_valid latency is 2 cycles with an empty FIFO; sustained 1 read/cycle when resp_ready is held high.
REQ-022 Push and pop in the same cycle: count unchanged, order preserved; push into a full FIFO cannot occur (credit rule); FIFO pointers wrap modulo 3.
REQ-023 A write to address A granted in cycle N is visible to any read of A granted in cycle N+1 or later.
REQ-024 With resp_ready low, reads stall once credit reaches 0; writes continue to be granted.

Reset
REQ-025 During reset and the cycle it is sampled: RW0_en=0, rreq_ready=0, wreq_ready=0, resp_valid=0.
REQ-026 After reset: FIFO empty, inflight=0, round-robin favours write; reset mid-operation discards in-flight reads and buffered responses.
REQ-027 No SRAM access is issued in any cycle where reset is high.

Verification
REQ-028 Write 0x1234 to addr 0x005, then read 0x005 -> RW0_en=1/wmode=1/addr=0x005 on the write cycle; resp_data=0x1234 two cycles after the read handshake.
REQ-029 Reads to addr 0..7 on back-to-back cycles, resp_ready=1 -> 8 responses on consecutive cycles, in address order, no rreq_ready gap.
REQ-030 resp_ready=0, reads issued continuously -> exactly 3 reads accepted, rreq_ready then 0; release resp_ready -> 3 responses in order, then reads resume.
REQ-031 rreq_valid and wreq_valid both held high for 4 cycles after reset -> grants W,R,W,R; RW0_wmode toggles 1,0,1,0.
REQ-032 Assert reset the cycle after a read fires -> no resp_valid after reset; next read of a pre-written address returns the correct data at 2-cycle latency.
REQ-033 Write 0xBEEF to addr 0x1FF, read addr 0x1FF the next cycle -> resp_data=0xBEEF (top address, write-then-read hazard).
